// File: rtl/led_status_sequencer.sv
// Status LED sequencer: heartbeat, idle and fault blink codes
// driving a registered RGB colour-selector index.
module led_status_sequencer #(
    parameter int TICK_DIV    = 1200000,
    parameter int BLINK_TICKS = 2,
    parameter int GAP_TICKS   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       run,
    input  logic       fault,
    input  logic [2:0] fault_code,
    input  logic       clear,
    output logic [3:0] color_index,
    output logic       fault_active
);

    localparam int PH_MAX = (2 * BLINK_TICKS > GAP_TICKS) ?
                            2 * BLINK_TICKS : GAP_TICKS;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int SW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_OFF, S_IDLE, S_RUN, S_F_ON, S_F_OFF, S_F_GAP
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [SW-1:0] presc;
    logic [PW-1:0] phase;
    logic [2:0]    blink_cnt;
    logic [2:0]    code_reg;
    logic          tick;
    logic          set_fault;
    logic          clr_fault;
    logic          blink_inc;
    logic          blink_clr;
    logic          last_blink;
    logic          last_gap;
    logic          last_hb;

    assign tick       = enable && (presc == SW'(TICK_DIV - 1));
    assign last_blink = phase == PW'(BLINK_TICKS - 1);
    assign last_gap   = phase == PW'(GAP_TICKS - 1);
    assign last_hb    = phase == PW'(2 * BLINK_TICKS - 1);

    function automatic logic [3:0] color_of(state_t s, logic [PW-1:0] p);
        logic [3:0] c;
        c = 4'b0000;
        unique case (s)
            S_IDLE:  c = 4'b1010;
            S_RUN:   c = (p < PW'(BLINK_TICKS)) ? 4'b0010 : 4'b1001;
            S_F_ON:  c = 4'b0001;
            S_F_GAP: c = 4'b1000;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // A new fault outranks clear; clear outranks the enable gate so it is
    // honoured even while dark.
    always_comb begin
        nxt       = state;
        set_fault = 1'b0;
        clr_fault = 1'b0;
        blink_inc = 1'b0;
        blink_clr = 1'b0;
        if (fault && !fault_active) begin
            set_fault = 1'b1;
            blink_clr = 1'b1;
            nxt       = enable ? S_F_ON : S_OFF;
        end else if (clear && !fault && fault_active) begin
            clr_fault = 1'b1;
            nxt       = !enable ? S_OFF : (run ? S_RUN : S_IDLE);
        end else if (!enable) begin
            nxt = S_OFF;
        end else begin
            unique case (state)
                S_OFF: begin
                    blink_clr = 1'b1;
                    nxt = fault_active ? S_F_ON : (run ? S_RUN : S_IDLE);
                end
                S_IDLE: if (run) nxt = S_RUN;
                S_RUN:  if (!run) nxt = S_IDLE;
                S_F_ON: if (tick && last_blink) nxt = S_F_OFF;
                S_F_OFF: begin
                    if (tick && last_blink) begin
                        blink_inc = 1'b1;
                        nxt = (3'(blink_cnt + 3'd1) == code_reg) ?
                              S_F_GAP : S_F_ON;
                    end
                end
                S_F_GAP: begin
                    if (tick && last_gap) begin
                        blink_clr = 1'b1;
                        nxt       = S_F_ON;
                    end
                end
                default: nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_OFF;
            presc        <= '0;
            phase        <= '0;
            blink_cnt    <= '0;
            code_reg     <= '0;
            fault_active <= 1'b0;
            color_index  <= 4'b0000;
        end else begin
            state       <= nxt;
            color_index <= color_of(state, phase);
            if (nxt != state || !enable) begin
                presc <= '0;
                phase <= '0;
            end else if (tick) begin
                presc <= '0;
                phase <= (state == S_RUN && last_hb) ? '0 : phase + PW'(1);
            end else begin
                presc <= presc + SW'(1);
            end
            if (set_fault) begin
                fault_active <= 1'b1;
                code_reg     <= (fault_code == 3'd0) ? 3'd1 : fault_code;
            end else if (clr_fault) begin
                fault_active <= 1'b0;
            end
            if (blink_clr) begin
                blink_cnt <= '0;
            end else if (blink_inc) begin
                blink_cnt <= blink_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_status_sequencer.sv
// Scoreboard bench for led_status_sequencer with small timing parameters:
// stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_led_status_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       run;
    logic       fault;
    logic [2:0] fault_code;
    logic       clear;
    logic [3:0] color_index;
    logic       fault_active;

    typedef struct {
        int         cyc;
        logic [3:0] col;
        logic       fa;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    led_status_sequencer #(
        .TICK_DIV(4),
        .BLINK_TICKS(2),
        .GAP_TICKS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .run(run),
        .fault(fault),
        .fault_code(fault_code),
        .clear(clear),
        .color_index(color_index),
        .fault_active(fault_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)",
                         e.tag, e.cyc, cyc);
            end else if (color_index !== e.col || fault_active !== e.fa) begin
                fails++;
                $display("FAIL %s @%0d: color_index=%b fault_active=%b, expected %b/%b",
                         e.tag, cyc, color_index, fault_active, e.col, e.fa);
            end
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int off, input logic [3:0] col,
                             input logic fa, input string tag);
        exp_t e;
        e.cyc = cyc + off;
        e.col = col;
        e.fa  = fa;
        e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; run = 1'b0;
        fault = 1'b0; fault_code = 3'd0; clear = 1'b0;

        // reset and idle
        go(2);
        expect_at(0, 4'b0000, 1'b0, "reset");
        rst_n = 1'b1;
        expect_at(1, 4'b0000, 1'b0, "post_rst_lat");
        expect_at(2, 4'b1010, 1'b0, "idle");
        go(4);

        // heartbeat
        run = 1'b1;
        expect_at(1,  4'b1010, 1'b0, "run_lat");
        expect_at(2,  4'b0010, 1'b0, "hb_g_first");
        expect_at(9,  4'b0010, 1'b0, "hb_g_last");
        expect_at(10, 4'b1001, 1'b0, "hb_low_first");
        expect_at(17, 4'b1001, 1'b0, "hb_low_last");
        expect_at(18, 4'b0010, 1'b0, "hb_wrap");
        go(20);

        // code 3 burst, second fault (code 5) ignored
        fault = 1'b1; fault_code = 3'd3;
        expect_at(2,  4'b0001, 1'b1, "f3_on1");
        expect_at(9,  4'b0001, 1'b1, "f3_on1_end");
        expect_at(10, 4'b0000, 1'b1, "f3_off1");
        expect_at(17, 4'b0000, 1'b1, "f3_off1_end");
        expect_at(18, 4'b0001, 1'b1, "f3_on2");
        expect_at(34, 4'b0001, 1'b1, "f3_on3");
        expect_at(42, 4'b0000, 1'b1, "f3_off3");
        expect_at(49, 4'b0000, 1'b1, "f3_off3_end");
        expect_at(50, 4'b1000, 1'b1, "f3_gap");
        expect_at(61, 4'b1000, 1'b1, "f3_gap_end");
        expect_at(62, 4'b0001, 1'b1, "f3_restart");
        go(1);
        fault = 1'b0;
        go(19);
        fault = 1'b1; fault_code = 3'd5;
        go(1);
        fault = 1'b0;
        go(42);

        // clear together with fault is ignored
        clear = 1'b1; fault = 1'b1; fault_code = 3'd2;
        expect_at(2, 4'b0001, 1'b1, "clr_f_on");
        expect_at(7, 4'b0000, 1'b1, "clr_f_off");
        go(1);
        clear = 1'b0; fault = 1'b0;
        go(16);

        // clear mid F_ON with run=1; clear with no fault has no effect
        clear = 1'b1;
        expect_at(1,  4'b0001, 1'b0, "clr_fa_drop");
        expect_at(2,  4'b0010, 1'b0, "clr_run");
        expect_at(9,  4'b0010, 1'b0, "clr_idle_g");
        expect_at(10, 4'b1001, 1'b0, "clr_noeffect");
        go(1);
        clear = 1'b0;
        go(2);
        clear = 1'b1;
        go(1);
        clear = 1'b0;
        go(10);

        // code 0 gives one blink; enable drop in F_GAP; restart at F_ON
        fault = 1'b1; fault_code = 3'd0;
        expect_at(2,  4'b0001, 1'b1, "f0_on");
        expect_at(9,  4'b0001, 1'b1, "f0_on_end");
        expect_at(10, 4'b0000, 1'b1, "f0_off");
        expect_at(17, 4'b0000, 1'b1, "f0_off_end");
        expect_at(18, 4'b1000, 1'b1, "f0_gap");
        expect_at(29, 4'b1000, 1'b1, "f0_gap_end");
        expect_at(30, 4'b0001, 1'b1, "f0_on2");
        expect_at(49, 4'b1000, 1'b1, "dis_lat");
        expect_at(50, 4'b0000, 1'b1, "dis_dark");
        expect_at(53, 4'b0000, 1'b1, "dis_hold");
        expect_at(56, 4'b0001, 1'b1, "en_restart");
        expect_at(63, 4'b0001, 1'b1, "en_on_end");
        expect_at(64, 4'b0000, 1'b1, "en_off");
        go(1);
        fault = 1'b0;
        go(47);
        enable = 1'b0;
        go(6);
        enable = 1'b1;
        go(12);

        // asynchronous reset mid-burst
        rst_n = 1'b0;
        expect_at(0, 4'b0000, 1'b0, "rst_async");
        go(2);
        rst_n = 1'b1;
        expect_at(1, 4'b0000, 1'b0, "rst_rel_lat");
        expect_at(2, 4'b0010, 1'b0, "rst_rel_run");
        go(4);

        // fault and clear while disabled
        enable = 1'b0;
        expect_at(2, 4'b0000, 1'b0, "off_dark");
        go(3);
        fault = 1'b1; fault_code = 3'd2;
        go(1);
        fault = 1'b0;
        expect_at(0, 4'b0000, 1'b1, "off_fault_latch");
        clear = 1'b1;
        go(1);
        clear = 1'b0;
        expect_at(0, 4'b0000, 1'b0, "off_clear");
        go(1);
        enable = 1'b1;
        expect_at(1, 4'b0000, 1'b0, "reen_lat");
        expect_at(2, 4'b0010, 1'b0, "reen_run");
        go(4);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d checks pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/led_status_sequencer.md
LED_STATUS_SEQUENCER -- requirements
Module: led_status_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1200000, clk cycles per timing tick (100 ms at 12 MHz); legal minimum 2.
REQ-002 Parameter BLINK_TICKS, default 2, ticks per fault-blink on-phase and per off-phase, and per heartbeat half-period; legal minimum 1.
REQ-003 Parameter GAP_TICKS, default 10, ticks of pause between fault-blink bursts; legal minimum 1.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  LED indication enable; 0 forces dark.
REQ-007 run  in  1  converter running status, level.
REQ-008 fault  in  1  fault request, level, sampled every clk.
REQ-009 fault_code  in  3  fault identifier = number of red blinks per burst.
REQ-010 clear  in  1  single-cycle fault acknowledge.
REQ-011 color_index  out  4  registered code for the RGB colour selector (0000 off, 0001 red, 0010 green, 1000 red low, 1001 green low, 1010 yellow low).
REQ-012 fault_active  out  1  registered; high while a fault is latched.

Function
REQ-013 Prescaler shall count 0..TICK_DIV-1, emit a one-cycle tick at TICK_DIV-1, wrap to 0; held at 0 while enable=0 and zeroed on every state entry.
REQ-014 States: OFF, IDLE, RUN, F_ON, F_OFF, F_GAP; phase counter counts ticks within current state, zeroed on entry.
REQ-015 Colour per state: OFF 0000; IDLE 1010; RUN 0010 for BLINK_TICKS ticks, then 1001 for BLINK_TICKS ticks, repeating; F_ON 0001; F_OFF 0000; F_GAP 1000.
REQ-016 color_index shall update on the clk edge after the state/phase change (one-cycle registered latency).
REQ-017 enable=0 in any state -> OFF next cycle; fault latch, code_reg retained.
REQ-018 OFF with enable=1 -> F_ON if fault_active, else RUN if run=1, else IDLE.
REQ-019 IDLE<->RUN shall follow run level, one cycle after run changes; RUN entry starts heartbeat at 0010.
REQ-020 fault=1 while enable=1 and fault_active=0 -> latch code_reg=fault_code (000 stored as 001), fault_active=1, enter F_ON, blink_cnt=0, next cycle.
REQ-021 fault=1 while fault_active=1 shall be ignored (first code wins, no restart).
REQ-022 F_ON -> F_OFF after BLINK_TICKS ticks; F_OFF end increments blink_cnt; if new blink_cnt==code_reg -> F_GAP, else F_ON.
REQ-023 F_GAP -> F_ON after GAP_TICKS ticks, blink_cnt=0.
REQ-024 clear=1 with fault=0 and fault_active=1 -> fault_active=0, enter RUN/IDLE per run, next cycle, from any F_* state.
REQ-025 clear=1 with fault=1 same cycle: clear ignored, fault remains latched.
REQ-026 clear while fault_active=0 shall have no effect.
REQ-027 fault or clear arriving while enable=0: fault latched (state stays OFF), clear honoured identically.

Reset
REQ-028 rst_n=0 shall asynchronously force state OFF, color_index 0000, fault_active 0, prescaler, phase, blink_cnt, code_reg to 0.
REQ-029 After rst_n release, first state update on the next rising clk edge; reset mid-burst abandons the burst.

Verification (TICK_DIV=4, BLINK_TICKS=2, GAP_TICKS=3)
REQ-030 Reset, enable=1, run=0 -> color_index 1010 two cycles after release; run=1 -> 0010 for 8 clk, 1001 for 8 clk, repeating.
REQ-031 fault=1 pulse with fault_code=3 -> fault_active=1; color 0001/0000 each 8 clk, three times, then 1000 for 12 clk, repeat.
REQ-032 fault_code=0 -> exactly one red blink per burst; second fault with code 5 during burst -> pattern unchanged.
REQ-033 clear with fault=0 mid-F_ON, run=1 -> fault_active=0 and color 0010 within 2 clk; clear with fault=1 -> no change.
REQ-034 enable=0 during F_GAP -> 0000 within 2 clk; enable=1 -> burst restarts at F_ON (0001); rst_n=0 mid-burst -> 0000 immediately, fault_active=0.
